switch_pulse_gen: RTL and testbench
===================================

SWITCH_PULSE_GEN -- requirements
Module: switch_pulse_gen

Interface
- REQ-001 SHALL have parameter N_CH, default 2: number of independent switch channels (1..16).
- REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles needed to accept a level change (>=1).
- REQ-003 SHALL have parameter COUNT_W, default 4: width of each per-channel event counter.
- REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
- REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-006 SHALL have port sw_in, input, N_CH: raw asynchronous switch levels.
- REQ-007 SHALL have port edge_sel, input, 2: 00 rise, 01 fall, 10 both, 11 pulses disabled.
- REQ-008 SHALL have port cnt_clr, input, 1: synchronous clear of all event counters.
- REQ-009 SHALL have port pulse_out, output, N_CH: one-cycle event pulse per channel.
- REQ-010 SHALL have port level_out, output, N_CH: debounced switch level per channel.
- REQ-011 SHALL have port evt_count, output, N_CH*COUNT_W: per-channel event counts; channel i in bits [i*COUNT_W +: COUNT_W].
- REQ-012 SHALL have port any_pulse, output, 1: OR of pulse_out.

Function
- REQ-013 Each channel SHALL pass sw_in through a 2-flop synchronizer; s = second flop output.
- REQ-014 Each channel SHALL hold a debounce counter: s==level gives cnt<=0; s!=level and cnt<DEBOUNCE_CYCLES-1 gives cnt<=cnt+1; s!=level and cnt==DEBOUNCE_CYCLES-1 gives level<=s, cnt<=0.
- REQ-015 Latency: if edge k is the first to sample a new stable sw_in value, level_out SHALL change after edge k+1+DEBOUNCE_CYCLES (k+5 at default).
- REQ-016 A synchronized excursion shorter than DEBOUNCE_CYCLES cycles SHALL reset the counter and produce no level change, pulse or count.
- REQ-017 pulse_out[i] SHALL be registered, asserting for exactly one cycle on the same edge level_out[i] changes, only if the change direction matches edge_sel.
- REQ-018 edge_sel==11 SHALL suppress all pulses and counts; level_out still tracks.
- REQ-019 edge_sel SHALL be sampled at the edge the level changes; mid-debounce changes affect only that decision.
- REQ-020 evt_count[i] SHALL increment on the same edge pulse_out[i] asserts, saturating at 2^COUNT_W-1.
- REQ-021 cnt_clr SHALL zero all counters on the next edge; when coincident with a pulse, clear wins (count 0, pulse still emitted).
- REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each pulse and count in the same cycle.
- REQ-023 any_pulse SHALL be combinational OR of registered pulse_out, high in the same cycles.

Reset
- REQ-024 While rst is high, sync flops, debounce counters, level_out, pulse_out, evt_count and any_pulse SHALL be 0 after each edge.
- REQ-025 Reset SHALL dominate cnt_clr and in-flight debounce; a switch held high through reset is treated as a new rising change after release (pulse at release edge + 1 + DEBOUNCE_CYCLES... measured per REQ-015 from the first post-reset edge).

Structure
- REQ-026 Package switch_pulse_pkg SHALL hold edge_sel encodings (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF) and parameter defaults.
- REQ-027 Sub-module switch_debounce_ch SHALL implement one channel (sync, debounce, edge detect, counter), instantiated N_CH times by generate.

Verification (N_CH=2, DEBOUNCE_CYCLES=4, COUNT_W=4)
- REQ-028 Reset: rst high 2 cycles with sw_in=11 -> all outputs 0; after release, pulse_out=11 one cycle at post-reset edge k+5, evt_count={4'd1,4'd1}.
- REQ-029 Clean press, edge_sel=00: sw_in[0] 0->1 held 10 cycles then 0 -> pulse_out[0] one cycle at k+5, level_out[0]=1, count0=1; release drops level at k+5 with no pulse.
- REQ-030 Glitch: sw_in[0] high 3 cycles -> level_out, pulse_out, evt_count unchanged.
- REQ-031 Both-edge and simultaneous: edge_sel=10, sw_in 00->11 then 11->00 -> pulse_out=11 and any_pulse=1 one cycle each transition; counts reach 2 each.
- REQ-032 Saturation/clear: 17 rising events on ch1 -> count1=15; cnt_clr coincident with 18th pulse -> pulse_out[1]=1, count1=0.
- REQ-033 Reset mid-debounce: rst asserted 2 cycles after sw_in[0] rises -> no pulse, level_out[0]=0, full latency restarts after release.

Source files
------------

// File: rtl/switch_pulse_pkg.sv
// Shared encodings and defaults for the debounced switch pulse generator.
package switch_pulse_pkg;

    localparam int N_CH_DEF            = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int COUNT_W_DEF         = 4;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_sel_e;

    // True when a level change in the given direction should produce a pulse.
    function automatic logic edge_match(input logic [1:0] sel, input logic rising);
        logic hit;
        hit = 1'b0;
        case (sel)
            EDGE_RISE: hit = rising;
            EDGE_FALL: hit = ~rising;
            EDGE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: 2-flop synchronizer, debounce counter, edge-qualified
// pulse and a saturating event counter.
module switch_debounce_ch
    import switch_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int COUNT_W         = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_in,
    input  logic [1:0]         edge_sel,
    input  logic               cnt_clr,
    output logic               pulse_out,
    output logic               level_out,
    output logic [COUNT_W-1:0] evt_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]    DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               level_q, level_d;
    logic               pulse_q, pulse_d;
    logic [COUNT_W-1:0] count_q, count_d;

    always_comb begin
        sync1_d  = sw_in;
        sync2_d  = sync1_q;
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        pulse_d  = 1'b0;
        count_d  = count_q;

        // Any return to the accepted level restarts the stability window.
        if (sync2_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
            level_d  = sync2_q;
            db_cnt_d = '0;
            pulse_d  = edge_match(edge_sel, sync2_q);
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        // Clear beats a coincident increment; the pulse itself still goes out.
        if (cnt_clr) begin
            count_d = '0;
        end else if (pulse_d && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            count_q  <= count_d;
        end
    end

    assign pulse_out = pulse_q;
    assign level_out = level_q;
    assign evt_count = count_q;

endmodule

// File: rtl/switch_pulse_gen.sv
// Multi-channel debounced switch pulse generator; channels are independent
// and share only edge_sel and cnt_clr.
module switch_pulse_gen
    import switch_pulse_pkg::*;
#(
    parameter int N_CH            = N_CH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int COUNT_W         = COUNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         sw_in,
    input  logic [1:0]              edge_sel,
    input  logic                    cnt_clr,
    output logic [N_CH-1:0]         pulse_out,
    output logic [N_CH-1:0]         level_out,
    output logic [N_CH*COUNT_W-1:0] evt_count,
    output logic                    any_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        switch_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .COUNT_W        (COUNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .sw_in    (sw_in[i]),
            .edge_sel (edge_sel),
            .cnt_clr  (cnt_clr),
            .pulse_out(pulse_out[i]),
            .level_out(level_out[i]),
            .evt_count(evt_count[i*COUNT_W +: COUNT_W])
        );
    end

    assign any_pulse = |pulse_out;

endmodule

// File: tb/tb_switch_pulse_gen.sv
// Scoreboard bench for switch_pulse_gen at N_CH=2, DEBOUNCE_CYCLES=4, COUNT_W=4.
module tb_switch_pulse_gen;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sw_in = 2'b00;
    logic [1:0] edge_sel = 2'b00;
    logic       cnt_clr = 1'b0;
    logic [1:0] pulse_out;
    logic [1:0] level_out;
    logic [7:0] evt_count;
    logic       any_pulse;

    typedef struct {
        int         cyc;
        logic [1:0] pulse;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   mcnt[2];

    switch_pulse_gen #(.N_CH(2), .DEBOUNCE_CYCLES(DB), .COUNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_in    (sw_in),
        .edge_sel (edge_sel),
        .cnt_clr  (cnt_clr),
        .pulse_out(pulse_out),
        .level_out(level_out),
        .evt_count(evt_count),
        .any_pulse(any_pulse)
    );

    always #5 clk = ~clk;

    // Advance one edge, then pop the scoreboard if an event is due this cycle.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        total++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (pulse_out !== e.pulse || any_pulse !== 1'b1 || evt_count !== e.cnt) begin
                bad++;
                $display("FAIL sb_event cyc=%0d got pulse=%b any=%b cnt=%h want pulse=%b any=1 cnt=%h",
                         cyc, pulse_out, any_pulse, evt_count, e.pulse, e.cnt);
            end
        end else if (pulse_out !== 2'b00 || any_pulse !== 1'b0) begin
            bad++;
            $display("FAIL sb_quiet cyc=%0d got pulse=%b any=%b want 00/0", cyc, pulse_out, any_pulse);
        end
    endtask

    // Sample edge k is cyc+1; the pulse lands after edge k+1+DB.
    task automatic expect_pulse(input logic [1:0] m);
        for (int c = 0; c < 2; c++)
            if (m[c] && mcnt[c] < 15) mcnt[c]++;
        sb.push_back('{cyc + 2 + DB, m, {4'(mcnt[1]), 4'(mcnt[0])}});
    endtask

    task automatic test_reset();
        rst = 1'b1; sw_in = 2'b11; edge_sel = 2'b00; cnt_clr = 1'b1;
        cycle(); cycle();
        total++;
        if (level_out !== 2'b00 || pulse_out !== 2'b00 || evt_count !== 8'h00 || any_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got lvl=%b pls=%b cnt=%h any=%b want all 0",
                     level_out, pulse_out, evt_count, any_pulse);
        end
        rst = 1'b0; cnt_clr = 1'b0;
        mcnt[0] = 0; mcnt[1] = 0;
        expect_pulse(2'b11);
        repeat (8) cycle();
        total++;
        if (level_out !== 2'b11) begin
            bad++; $display("FAIL reset_release_level got %b want 11", level_out);
        end
        sw_in = 2'b00;
        repeat (8) cycle();
    endtask

    task automatic test_press();
        edge_sel = 2'b00; sw_in = 2'b01;
        expect_pulse(2'b01);
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i == 5 || i == 6) begin
                total++;
                if (level_out[0] !== (i == 6)) begin
                    bad++; $display("FAIL press_level step=%0d got %b want %b", i, level_out[0], i == 6);
                end
            end
        end
        total++;
        if (evt_count[3:0] !== 4'd2) begin
            bad++; $display("FAIL press_count got %0d want 2", evt_count[3:0]);
        end
        sw_in = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (i == 5 || i == 6) begin
                total++;
                if (level_out[0] !== (i == 5)) begin
                    bad++; $display("FAIL release_level step=%0d got %b want %b", i, level_out[0], i == 5);
                end
            end
        end
    endtask

    task automatic test_glitch();
        sw_in = 2'b01;
        repeat (3) cycle();
        sw_in = 2'b00;
        repeat (8) cycle();
        total++;
        if (level_out !== 2'b00 || evt_count !== {4'(mcnt[1]), 4'(mcnt[0])}) begin
            bad++; $display("FAIL glitch got lvl=%b cnt=%h want 00 cnt=%h",
                            level_out, evt_count, {4'(mcnt[1]), 4'(mcnt[0])});
        end
    endtask

    task automatic test_off();
        // Disabled edges: level still tracks, nothing pulses or counts.
        edge_sel = 2'b11; sw_in = 2'b10;
        repeat (8) cycle();
        total++;
        if (level_out !== 2'b10) begin
            bad++; $display("FAIL off_level got %b want 10", level_out);
        end
        sw_in = 2'b00;
        repeat (8) cycle();
        // edge_sel only matters at the edge the level changes.
        sw_in = 2'b01;
        expect_pulse(2'b01);
        repeat (3) cycle();
        edge_sel = 2'b00;
        repeat (5) cycle();
        edge_sel = 2'b11; sw_in = 2'b00;
        repeat (3) cycle();
        edge_sel = 2'b00;
        repeat (5) cycle();
        total++;
        if (level_out !== 2'b00) begin
            bad++; $display("FAIL off_release_level got %b want 00", level_out);
        end
    endtask

    task automatic test_back_to_back();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        mcnt[0] = 0; mcnt[1] = 0;
        total++;
        if (evt_count !== 8'h00) begin
            bad++; $display("FAIL clear_count got %h want 00", evt_count);
        end
        edge_sel = 2'b10; sw_in = 2'b11;
        expect_pulse(2'b11);
        repeat (8) cycle();
        sw_in = 2'b00;
        expect_pulse(2'b11);
        repeat (8) cycle();
        total++;
        if (evt_count !== 8'h22) begin
            bad++; $display("FAIL both_count got %h want 22", evt_count);
        end
    endtask

    task automatic test_saturation();
        edge_sel = 2'b00;
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        mcnt[0] = 0; mcnt[1] = 0;
        for (int n = 0; n < 17; n++) begin
            sw_in = 2'b10;
            expect_pulse(2'b10);
            repeat (6) cycle();
            sw_in = 2'b00;
            repeat (7) cycle();
        end
        total++;
        if (evt_count[7:4] !== 4'd15) begin
            bad++; $display("FAIL sat_count got %0d want 15", evt_count[7:4]);
        end
        // Clear lands on the same edge as the 18th pulse.
        sw_in = 2'b10;
        mcnt[0] = 0; mcnt[1] = 0;
        sb.push_back('{cyc + 2 + DB, 2'b10, 8'h00});
        repeat (5) cycle();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        sw_in = 2'b00;
        repeat (8) cycle();
        total++;
        if (evt_count !== 8'h00) begin
            bad++; $display("FAIL clr_vs_pulse got %h want 00", evt_count);
        end
    endtask

    task automatic test_reset_mid();
        edge_sel = 2'b00; sw_in = 2'b01;
        repeat (2) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        total++;
        if (level_out !== 2'b00 || evt_count !== 8'h00) begin
            bad++; $display("FAIL mid_reset got lvl=%b cnt=%h want 00/00", level_out, evt_count);
        end
        rst = 1'b0;
        mcnt[0] = 0; mcnt[1] = 0;
        expect_pulse(2'b01);
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (i == 5 || i == 6) begin
                total++;
                if (level_out[0] !== (i == 6)) begin
                    bad++; $display("FAIL mid_reset_level step=%0d got %b want %b", i, level_out[0], i == 6);
                end
            end
        end
        sw_in = 2'b00;
        repeat (8) cycle();
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_off();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
